snake_body_ctrl: RTL and testbench



---
 rtl/snake_body_ctrl_pkg.sv | 27 ++
 rtl/snake_next_head.sv | 44 ++++
 rtl/snake_body_ctrl.sv | 121 ++++++++++++
 tb/tb_snake_body_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/snake_body_ctrl_pkg.sv
// Shared snake game definitions: play state, direction codes, grid defaults.
// Imported by the body controller, food generator and renderer.
package snake_body_ctrl_pkg;

  localparam logic [1:0] PLAY_STATE = 2'b01;

  localparam int GRID_W_DEF = 40;
  localparam int GRID_H_DEF = 30;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
  } cell_t;

  // Same axis, opposite sense.
  function automatic logic is_reverse(dir_t a, dir_t b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Next head cell from current head and direction.
// Wall is judged on the current head, so underflow never matters.
module snake_next_head
  import snake_body_ctrl_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF
) (
  input  logic [5:0] head_x,
  input  logic [5:0] head_y,
  input  logic [1:0] dir,
  output logic [5:0] next_x,
  output logic [5:0] next_y,
  output logic       wall
);

  localparam logic [5:0] XMAX = 6'(GRID_W - 2);
  localparam logic [5:0] YMAX = 6'(GRID_H - 2);

  always_comb begin
    next_x = head_x;
    next_y = head_y;
    wall   = 1'b0;
    unique case (dir_t'(dir))
      DIR_UP: begin
        wall   = head_y <= 6'd1;
        next_y = head_y - 6'd1;
      end
      DIR_DOWN: begin
        wall   = head_y >= YMAX;
        next_y = head_y + 6'd1;
      end
      DIR_LEFT: begin
        wall   = head_x <= 6'd1;
        next_x = head_x - 6'd1;
      end
      DIR_RIGHT: begin
        wall   = head_x >= XMAX;
        next_x = head_x + 6'd1;
      end
    endcase
  end

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake body stage: segment shift store, direction filter, growth,
// wall/self collision and renderer body lookup.
module snake_body_ctrl
  import snake_body_ctrl_pkg::*;
#(
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int GRID_W   = GRID_W_DEF,
  parameter int GRID_H   = GRID_H_DEF,
  parameter int START_X  = 20,
  parameter int START_Y  = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] game_state,
  input  logic       step,
  input  logic [1:0] dir_req,
  input  logic       grow,
  input  logic [5:0] query_x,
  input  logic [5:0] query_y,
  output logic [5:0] head_x,
  output logic [5:0] head_y,
  output logic [4:0] snake_len,
  output logic       dead,
  output logic       body_hit
);

  cell_t      seg [MAX_LEN];
  logic [4:0] len;
  dir_t       dir;
  dir_t       pend_dir;
  logic       grow_pend;

  logic [5:0] nx;
  logic [5:0] ny;
  logic       wall;

  logic [MAX_LEN-1:0] hit_next;
  logic [MAX_LEN-1:0] hit_query;

  logic play;
  logic growing;
  logic move;
  logic collide;
  logic adv;

  function automatic cell_t init_seg(int i);
    cell_t c;
    c.x = 6'(START_X - i);
    c.y = 6'(START_Y);
    return c;
  endfunction

  snake_next_head #(
    .GRID_W(GRID_W),
    .GRID_H(GRID_H)
  ) u_next (
    .head_x(seg[0].x),
    .head_y(seg[0].y),
    .dir   (pend_dir),
    .next_x(nx),
    .next_y(ny),
    .wall  (wall)
  );

  assign play    = game_state == PLAY_STATE;
  assign growing = grow_pend | grow;
  assign move    = play & step & ~dead;

  // The tail vacates this step unless we grow, so it is only a hazard then.
  always_comb begin
    hit_next  = '0;
    hit_query = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (5'(k) < len) begin
        hit_next[k]  = (seg[k] == {nx, ny}) &&
                       ((5'(k) < len - 5'd1) || growing);
        hit_query[k] = seg[k] == {query_x, query_y};
      end
    end
  end

  assign collide  = |hit_next;
  assign adv      = move & ~wall & ~collide;
  assign body_hit = |hit_query;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) seg[i] <= init_seg(i);
      len       <= 5'(INIT_LEN);
      dir       <= DIR_RIGHT;
      pend_dir  <= DIR_RIGHT;
      dead      <= 1'b0;
      grow_pend <= 1'b0;
    end else if (!play) begin
      for (int i = 0; i < MAX_LEN; i++) seg[i] <= init_seg(i);
      len       <= 5'(INIT_LEN);
      dir       <= DIR_RIGHT;
      pend_dir  <= DIR_RIGHT;
      dead      <= 1'b0;
      grow_pend <= 1'b0;
    end else begin
      if (!is_reverse(dir_t'(dir_req), dir)) pend_dir <= dir_t'(dir_req);
      if (move) dir <= pend_dir;
      if (move && (wall || collide)) dead <= 1'b1;
      if (adv) begin
        seg[0] <= {nx, ny};
        for (int i = 1; i < MAX_LEN; i++) seg[i] <= seg[i-1];
        if (growing && len < 5'(MAX_LEN)) len <= len + 5'd1;
        grow_pend <= 1'b0;
      end else if (grow) begin
        grow_pend <= 1'b1;
      end
    end
  end

  assign head_x    = seg[0].x;
  assign head_y    = seg[0].y;
  assign snake_len = len;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Scoreboard bench for snake_body_ctrl: driver queues expectations,
// negedge monitor pops and compares against DUT outputs.
module tb_snake_body_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] game_state = 2'b01;
  logic       step = 1'b0;
  logic [1:0] dir_req = 2'b11;
  logic       grow = 1'b0;
  logic [5:0] query_x = 6'd0;
  logic [5:0] query_y = 6'd0;
  logic [5:0] head_x;
  logic [5:0] head_y;
  logic [4:0] snake_len;
  logic       dead;
  logic       body_hit;

  typedef struct {
    string      name;
    logic [5:0] hx;
    logic [5:0] hy;
    logic [4:0] len;
    logic       dead;
    logic       hit;
  } exp_t;

  exp_t q[$];
  logic chk_req = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  snake_body_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .game_state(game_state),
    .step      (step),
    .dir_req   (dir_req),
    .grow      (grow),
    .query_x   (query_x),
    .query_y   (query_y),
    .head_x    (head_x),
    .head_y    (head_y),
    .snake_len (snake_len),
    .dead      (dead),
    .body_hit  (body_hit)
  );

  always @(negedge clk) begin
    if (chk_req) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL monitor: output presented with empty scoreboard");
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({head_x, head_y, snake_len, dead, body_hit} !==
            {e.hx, e.hy, e.len, e.dead, e.hit}) begin
          miscompares++;
          $display("FAIL %s: got head=(%0d,%0d) len=%0d dead=%0d hit=%0d, want head=(%0d,%0d) len=%0d dead=%0d hit=%0d",
                   e.name, head_x, head_y, snake_len, dead, body_hit,
                   e.hx, e.hy, e.len, e.dead, e.hit);
        end
      end
    end
  end

  task automatic chk(string n, int hx, int hy, int len, int d, int h);
    exp_t e;
    e.name = n;
    e.hx   = 6'(hx);
    e.hy   = 6'(hy);
    e.len  = 5'(len);
    e.dead = 1'(d);
    e.hit  = 1'(h);
    q.push_back(e);
    chk_req = 1'b1;
    @(negedge clk);
    #1 chk_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    game_state = 2'b01;
    step = 1'b0;
    grow = 1'b0;
    dir_req = 2'b11;
    query_x = 6'd0;
    query_y = 6'd0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_step();
    @(posedge clk);
    #1 step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
  endtask

  task automatic grow_step();
    @(posedge clk);
    #1 step = 1'b1;
    grow = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    grow = 1'b0;
  endtask

  task automatic pulse_grow();
    grow = 1'b1;
    @(posedge clk);
    #1 grow = 1'b0;
  endtask

  task automatic set_q(int x, int y);
    query_x = 6'(x);
    query_y = 6'(y);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset state and straight moves
    do_reset();
    chk("reset_state", 20, 15, 3, 0, 0);
    for (int i = 0; i < 3; i++) do_step();
    chk("three_right", 23, 15, 3, 0, 0);

    // Reversal ignored, then a turn
    dir_req = 2'b10;
    do_step();
    chk("reverse_ignored", 24, 15, 3, 0, 0);
    dir_req = 2'b00;
    do_step();
    chk("turn_up", 24, 14, 3, 0, 0);

    // Growth, tail retention, saturation at MAX_LEN
    do_reset();
    pulse_grow();
    do_step();
    set_q(18, 15);
    chk("grow_pend_tail", 21, 15, 4, 0, 1);
    set_q(0, 0);
    grow_step();
    chk("grow_same_cycle", 22, 15, 5, 0, 0);
    for (int i = 0; i < 11; i++) grow_step();
    set_q(18, 15);
    chk("reach_max_len", 33, 15, 16, 0, 1);
    grow_step();
    chk("max_len_tail_gone", 34, 15, 16, 0, 0);
    set_q(19, 15);
    chk("max_len_last_seg", 34, 15, 16, 0, 1);
    set_q(0, 0);

    // Wall collision, sticky dead, restart via game_state
    do_reset();
    for (int i = 0; i < 18; i++) do_step();
    chk("at_right_edge", 38, 15, 3, 0, 0);
    do_step();
    chk("wall_dead", 38, 15, 3, 1, 0);
    do_step();
    chk("dead_sticky", 38, 15, 3, 1, 0);
    game_state = 2'b00;
    @(posedge clk);
    #1 game_state = 2'b01;
    chk("leave_play_reinit", 20, 15, 3, 0, 0);

    // Self collision with the body
    do_reset();
    dir_req = 2'b00;
    pulse_grow();
    do_step();
    chk("self_up", 20, 14, 4, 0, 0);
    dir_req = 2'b10;
    pulse_grow();
    do_step();
    chk("self_left", 19, 14, 5, 0, 0);
    dir_req = 2'b01;
    do_step();
    set_q(18, 15);
    chk("self_hit_dead", 19, 14, 5, 1, 1);
    set_q(0, 0);

    // Renderer queries and async reset mid-step
    do_reset();
    set_q(18, 15);
    chk("query_tail", 20, 15, 3, 0, 1);
    set_q(21, 15);
    chk("query_ahead", 20, 15, 3, 0, 0);
    set_q(20, 15);
    chk("query_head", 20, 15, 3, 0, 1);
    set_q(17, 15);
    chk("query_inactive", 20, 15, 3, 0, 0);
    set_q(0, 0);
    do_step();
    do_step();
    chk("pre_rst", 22, 15, 3, 0, 0);
    @(posedge clk);
    #1 step = 1'b1;
    rst = 1'b1;
    chk("rst_mid_step", 20, 15, 3, 0, 0);
    rst = 1'b0;
    step = 1'b0;

    @(posedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
